mdb_arbiter: RTL

Round-robin arbiter and sequencer for the 16-bit multi-drop register bus. Four requesters each present a data word and a 2-bit destination; the arbiter picks one winner, drives the shared `databus` and exactly one of `A_en/B_en/C_en/D_en` for one cycle, and acknowledges the winner with a one-cycle grant. It sits between the bus masters and the four destination registers (RegA..RegD) that load on their enable.

---
 rtl/mdb_pkg.sv | 23 ++
 rtl/mdb_rr_picker.sv | 22 ++
 rtl/mdb_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mdb_pkg.sv
// Shared types and helpers for the multi-drop register bus arbiter.
package mdb_pkg;
  localparam int NREQ = 4;

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  localparam logic [1:0] DEST_A = 2'd0;
  localparam logic [1:0] DEST_B = 2'd1;
  localparam logic [1:0] DEST_C = 2'd2;
  localparam logic [1:0] DEST_D = 2'd3;

  // One-hot enable ordered {A,B,C,D}: A is the MSB.
  function automatic logic [3:0] dest_to_en(input logic [1:0] d);
    logic [3:0] en;
    case (d)
      DEST_A:  en = 4'b1000;
      DEST_B:  en = 4'b0100;
      DEST_C:  en = 4'b0010;
      default: en = 4'b0001;
    endcase
    return en;
  endfunction
endpackage

// File: rtl/mdb_rr_picker.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module mdb_rr_picker
  import mdb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            valid,
  output logic [1:0]      win
);
  logic [1:0] w_idx;

  always_comb begin
    valid = |req;
    win   = last;
    w_idx = last;
    // Walk from lowest priority to highest so the nearest requester overwrites.
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = last + k[1:0];
      if (req[w_idx]) win = w_idx;
    end
  end
endmodule

// File: rtl/mdb_arbiter.sv
// Round-robin arbiter/sequencer driving the shared databus and one destination enable.
// Optional bus locking is enabled with `define MDB_ARB_LOCK_EN.
module mdb_arbiter
  import mdb_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [2*NREQ-1:0]  req_dest,
`ifdef MDB_ARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      databus,
  output logic               A_en,
  output logic               B_en,
  output logic               C_en,
  output logic               D_en,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_count
);
  state_t            r_state, w_state_nxt;
  logic [1:0]        r_last, w_last_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic [DW-1:0]     r_bus, w_bus_nxt;
  logic [3:0]        r_en, w_en_nxt;
  logic              r_busy, w_busy_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_rr_valid;
  logic [1:0]        w_rr_win, w_win;

  mdb_rr_picker u_picker (
    .req   (req),
    .last  (r_last),
    .valid (w_rr_valid),
    .win   (w_rr_win)
  );

`ifdef MDB_ARB_LOCK_EN
  logic       r_own_vld, w_own_vld_nxt;
  logic [1:0] r_own, w_own_nxt;
  logic       w_hold;
  assign w_hold = r_own_vld && req[r_own] && req_lock[r_own];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gnt_nxt   = '0;
    w_bus_nxt   = '0;
    w_en_nxt    = '0;
    w_busy_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_win       = w_rr_win;
`ifdef MDB_ARB_LOCK_EN
    w_own_vld_nxt = r_own_vld;
    w_own_nxt     = r_own;
`endif
    case (r_state)
      IDLE: begin
`ifdef MDB_ARB_LOCK_EN
        if (w_hold) w_win = r_own;
        else        w_own_vld_nxt = 1'b0;
`endif
        if (w_rr_valid) begin
          w_state_nxt      = DRIVE;
          w_last_nxt       = w_win;
          w_gnt_nxt[w_win] = 1'b1;
          w_bus_nxt        = req_data[int'(w_win)*DW +: DW];
          w_en_nxt         = dest_to_en(req_dest[int'(w_win)*2 +: 2]);
          w_busy_nxt       = 1'b1;
`ifdef MDB_ARB_LOCK_EN
          if (req_lock[w_win]) begin
            w_own_vld_nxt = 1'b1;
            w_own_nxt     = w_win;
          end
`endif
        end
      end
      DRIVE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_gnt   <= '0;
      r_bus   <= '0;
      r_en    <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
`ifdef MDB_ARB_LOCK_EN
      r_own_vld <= 1'b0;
      r_own     <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_bus   <= w_bus_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef MDB_ARB_LOCK_EN
      r_own_vld <= w_own_vld_nxt;
      r_own     <= w_own_nxt;
`endif
    end
  end

  assign gnt        = r_gnt;
  assign databus    = r_bus;
  assign A_en       = r_en[3];
  assign B_en       = r_en[2];
  assign C_en       = r_en[1];
  assign D_en       = r_en[0];
  assign busy       = r_busy;
  assign xfer_count = r_cnt;
endmodule
